// File: rtl/mvm_accumulator.sv
// Accumulates NUM_TILES lane captures from the stochastic MVM, then shifts, optionally ReLUs
// and saturates the sums into an output vector offered on a valid/ready handshake.
module mvm_accumulator #(
  parameter int LANES     = 4,
  parameter int IN_W      = 4,
  parameter int ACC_W     = 8,
  parameter int OUT_W     = 4,
  parameter int NUM_TILES = 4,
  parameter int SHIFT     = 1,
  parameter int RELU      = 1
) (
  input  logic                                i_clk_acc,
  input  logic                                i_rst_n_acc,
  input  logic                                i_ismvm,
  input  logic [LANES-1:0][IN_W-1:0]          i_wx_result,
  input  logic                                i_clear,
  input  logic                                i_ready,
  output logic                                o_valid,
  output logic [LANES-1:0][OUT_W-1:0]         o_y,
  output logic [$clog2(NUM_TILES+1)-1:0]      o_tile_cnt,
  output logic                                o_overrun
);

  localparam int CNT_W = $clog2(NUM_TILES+1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                   state;
  logic                     ismvm_q;
  logic signed [ACC_W-1:0]  acc      [LANES];
  logic signed [ACC_W-1:0]  in_ext   [LANES];
  logic signed [ACC_W-1:0]  acc_base [LANES];
  logic signed [ACC_W-1:0]  acc_sum  [LANES];
  logic [OUT_W-1:0]         y_next   [LANES];
  logic                     cap;
  logic                     xfer;
  logic                     fresh;
  logic                     take;
  logic                     last_tile;

  // Sum is one bit wider than the accumulator; differing top bits mean overflow.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
    logic signed [ACC_W-1:0] r;
    if (s[ACC_W] != s[ACC_W-1])
      r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      r = s[ACC_W-1:0];
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] shape_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    logic [ACC_W-OUT_W:0]    top;
    logic [OUT_W-1:0]        r;
    sh  = a >>> SHIFT;
    top = sh[ACC_W-1:OUT_W-1];
    if ((&top) || !(|top))
      r = sh[OUT_W-1:0];
    else
      r = top[ACC_W-OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    if ((RELU != 0) && r[OUT_W-1])
      r = '0;
    return r;
  endfunction

  // Capture happens on the falling edge of the MVM busy flag; results are still valid then.
  always_comb begin
    cap       = ismvm_q & ~i_ismvm;
    xfer      = o_valid & i_ready;
    fresh     = (state != ACCUM) | i_clear;
    take      = cap & ((state != OUT) | xfer);
    last_tile = fresh ? (NUM_TILES == 1) : ((int'(o_tile_cnt) + 1) == NUM_TILES);
    for (int l = 0; l < LANES; l++) begin
      in_ext[l]   = ACC_W'($signed(i_wx_result[l]));
      acc_base[l] = fresh ? '0 : acc[l];
      acc_sum[l]  = sat_acc({acc_base[l][ACC_W-1], acc_base[l]} + {in_ext[l][ACC_W-1], in_ext[l]});
      y_next[l]   = shape_out(acc_sum[l]);
    end
  end

  always_ff @(posedge i_clk_acc or negedge i_rst_n_acc) begin
    if (!i_rst_n_acc) begin
      state      <= IDLE;
      ismvm_q    <= 1'b0;
      o_valid    <= 1'b0;
      o_y        <= '0;
      o_tile_cnt <= '0;
      o_overrun  <= 1'b0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      ismvm_q <= i_ismvm;
      if (take) begin
        if (last_tile) begin
          for (int l = 0; l < LANES; l++) begin
            o_y[l] <= y_next[l];
            acc[l] <= '0;
          end
          o_tile_cnt <= '0;
          o_valid    <= 1'b1;
          state      <= OUT;
        end else begin
          for (int l = 0; l < LANES; l++) acc[l] <= acc_sum[l];
          o_tile_cnt <= fresh ? CNT_W'(1) : o_tile_cnt + CNT_W'(1);
          o_valid    <= 1'b0;
          state      <= ACCUM;
        end
      end else if (xfer || (i_clear && (state != OUT))) begin
        for (int l = 0; l < LANES; l++) acc[l] <= '0;
        o_tile_cnt <= '0;
        o_valid    <= 1'b0;
        state      <= IDLE;
      end
      // A capture arriving while a finished vector is still waiting is lost.
      if (cap && (state == OUT) && !xfer)
        o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mvm_accumulator.sv
// Scoreboard bench for mvm_accumulator: three parameterisations, a behavioural model
// pushes expected vectors on each completing capture and the bench pops them on transfer.
module tb_mvm_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ismvm [3];
  logic        clear [3];
  logic        ready [3];
  logic [15:0] wx    [3];

  logic        va, vb, vc, oa, ob, oc;
  logic [15:0] ya, yb, yc;
  logic [2:0]  tca;
  logic [1:0]  tcb;
  logic [4:0]  tcc;

  int          total = 0;
  int          bad   = 0;
  int          m_acc [3][4];
  int          m_cnt [3];
  bit          m_out [3];
  logic [15:0] sbq [$];

  always #5 clk = ~clk;

  mvm_accumulator dut_a (
    .i_clk_acc(clk), .i_rst_n_acc(rst_n), .i_ismvm(ismvm[0]), .i_wx_result(wx[0]),
    .i_clear(clear[0]), .i_ready(ready[0]), .o_valid(va), .o_y(ya),
    .o_tile_cnt(tca), .o_overrun(oa));

  mvm_accumulator #(.NUM_TILES(2), .SHIFT(0), .RELU(0)) dut_b (
    .i_clk_acc(clk), .i_rst_n_acc(rst_n), .i_ismvm(ismvm[1]), .i_wx_result(wx[1]),
    .i_clear(clear[1]), .i_ready(ready[1]), .o_valid(vb), .o_y(yb),
    .o_tile_cnt(tcb), .o_overrun(ob));

  mvm_accumulator #(.NUM_TILES(20), .SHIFT(5), .RELU(0)) dut_c (
    .i_clk_acc(clk), .i_rst_n_acc(rst_n), .i_ismvm(ismvm[2]), .i_wx_result(wx[2]),
    .i_clear(clear[2]), .i_ready(ready[2]), .o_valid(vc), .o_y(yc),
    .o_tile_cnt(tcc), .o_overrun(oc));

  function automatic int nt(int s);  return (s == 0) ? 4 : (s == 1) ? 2 : 20; endfunction
  function automatic int shf(int s); return (s == 0) ? 1 : (s == 1) ? 0 : 5;  endfunction
  function automatic int rl(int s);  return (s == 0) ? 1 : 0;                 endfunction

  function automatic logic get_valid(int s); return (s == 0) ? va : (s == 1) ? vb : vc; endfunction
  function automatic logic get_ovr(int s);   return (s == 0) ? oa : (s == 1) ? ob : oc; endfunction
  function automatic logic [15:0] get_y(int s); return (s == 0) ? ya : (s == 1) ? yb : yc; endfunction
  function automatic int get_tc(int s);
    return (s == 0) ? int'(tca) : (s == 1) ? int'(tcb) : int'(tcc);
  endfunction

  function automatic logic [15:0] pack(int a, int b, int c, int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_y(int s);
    logic [15:0] r;
    int t;
    for (int l = 0; l < 4; l++) begin
      t = m_acc[s][l] >>> shf(s);
      if (t > 7) t = 7;
      if (t < -8) t = -8;
      if (rl(s) != 0 && t < 0) t = 0;
      r[4*l +: 4] = 4'(t);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_cnt[s] = 0;
      m_out[s] = 1'b0;
      for (int l = 0; l < 4; l++) m_acc[s][l] = 0;
    end
    sbq.delete();
  endtask

  task automatic model_cap(int s, int v0, int v1, int v2, int v3, bit clr, bit xf);
    int v[4];
    v = '{v0, v1, v2, v3};
    if (m_out[s] && !xf) return;
    if (m_out[s] || clr) begin
      m_out[s] = 1'b0;
      m_cnt[s] = 0;
      for (int l = 0; l < 4; l++) m_acc[s][l] = 0;
    end
    for (int l = 0; l < 4; l++) begin
      m_acc[s][l] = m_acc[s][l] + v[l];
      if (m_acc[s][l] > 127)  m_acc[s][l] = 127;
      if (m_acc[s][l] < -128) m_acc[s][l] = -128;
    end
    m_cnt[s]++;
    if (m_cnt[s] == nt(s)) begin
      sbq.push_back(model_y(s));
      m_cnt[s] = 0;
      m_out[s] = 1'b1;
      for (int l = 0; l < 4; l++) m_acc[s][l] = 0;
    end
  endtask

  task automatic consume(int s, string tag);
    check({tag, "_valid"}, 32'(get_valid(s)), 32'd1);
    check({tag, "_sbq_nonempty"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) check({tag, "_y"}, 32'(get_y(s)), 32'(sbq.pop_front()));
  endtask

  // Busy high for one cycle, low at the capture edge; clear/ready accompany that edge.
  task automatic do_cap(int s, int v0, int v1, int v2, int v3, bit clr, bit rdy);
    bit xf;
    @(negedge clk);
    wx[s] = pack(v0, v1, v2, v3);
    ismvm[s] = 1'b1;
    @(negedge clk);
    ismvm[s] = 1'b0;
    clear[s] = clr;
    ready[s] = rdy;
    xf = rdy && m_out[s];
    if (xf) consume(s, "cap_xfer");
    @(posedge clk);
    model_cap(s, v0, v1, v2, v3, clr, xf);
    @(negedge clk);
    clear[s] = 1'b0;
    ready[s] = 1'b0;
  endtask

  task automatic drain(int s, string tag);
    for (int i = 0; i < 30 && !get_valid(s); i++) @(negedge clk);
    consume(s, tag);
    ready[s] = 1'b1;
    @(negedge clk);
    ready[s] = 1'b0;
    m_out[s] = 1'b0;
    check({tag, "_valid_drop"}, 32'(get_valid(s)), 32'd0);
    check({tag, "_tc_after"}, 32'(get_tc(s)), 32'd0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      ismvm[s] = 1'b0; clear[s] = 1'b0; ready[s] = 1'b0; wx[s] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(va), 0);
    check("rst_y", 32'(ya), 0);
    check("rst_tc", 32'(tca), 0);
    check("rst_ovr", 32'(oa), 0);
    rst_n = 1'b1;

    // Default instance: full vector, latency, hold with ready low.
    do_cap(0, 1, 2, -3, 7, 0, 0);  check("v1_tc1", get_tc(0), 1);
    do_cap(0, 2, -1, -3, 7, 0, 0); check("v1_tc2", get_tc(0), 2);
    do_cap(0, 3, 3, 3, 3, 0, 0);   check("v1_tc3", get_tc(0), 3);
    check("v1_notvalid", 32'(va), 0);
    do_cap(0, -4, 0, 5, 1, 0, 0);
    check("v1_latency", 32'(va), 1);
    check("v1_tc_out", get_tc(0), 0);
    check("v1_literal", 32'(ya), 32'(pack(1, 2, 1, 7)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("v1_hold_valid", 32'(va), 1);
      check("v1_hold_y", 32'(ya), 32'(pack(1, 2, 1, 7)));
    end
    drain(0, "v1");

    // Large negative sum saturates low and ReLU clamps to zero.
    for (int i = 0; i < 4; i++) do_cap(0, -8, -8, -8, -8, 0, 0);
    check("neg_literal", 32'(ya), 0);
    drain(0, "neg");

    // Overrun while holding, then capture coinciding with a transfer.
    for (int i = 0; i < 4; i++) do_cap(0, 1, 1, 1, 1, 0, 0);
    do_cap(0, 5, 5, 5, 5, 0, 0);
    check("ovr_set", 32'(oa), 1);
    check("ovr_tc", get_tc(0), 0);
    check("ovr_valid", 32'(va), 1);
    check("ovr_y_kept", 32'(ya), 32'(pack(2, 2, 2, 2)));
    do_cap(0, 3, -2, 1, 0, 0, 1);
    check("xcap_valid", 32'(va), 0);
    check("xcap_tc", get_tc(0), 1);
    check("xcap_ovr_sticky", 32'(oa), 1);

    // Clear alone, then clear together with a capture.
    @(negedge clk); clear[0] = 1'b1;
    @(negedge clk); clear[0] = 1'b0;
    m_cnt[0] = 0;
    for (int l = 0; l < 4; l++) m_acc[0][l] = 0;
    check("clr_tc", get_tc(0), 0);
    do_cap(0, 5, -5, 2, -2, 1, 0);
    check("clrcap_tc", get_tc(0), 1);
    for (int i = 0; i < 3; i++) do_cap(0, 0, 0, 0, 0, 0, 0);
    check("clrcap_literal", 32'(ya), 32'(pack(2, 0, 1, 0)));
    drain(0, "clrcap");

    // Asynchronous reset mid-accumulation and while holding output.
    do_cap(0, 4, 4, 4, 4, 0, 0);
    do_cap(0, 4, 4, 4, 4, 0, 0);
    #2 async_reset();
    check("arst_acc_tc", get_tc(0), 0);
    check("arst_acc_valid", 32'(va), 0);
    check("arst_acc_ovr", 32'(oa), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_cap(0, 1, 1, 1, 1, 0, 0);
    check("arst_pre_valid", 32'(va), 1);
    #3 async_reset();
    check("arst_out_valid", 32'(va), 0);
    check("arst_out_y", 32'(ya), 0);
    @(negedge clk); rst_n = 1'b1;
    do_cap(0, 7, -7, 6, -1, 0, 0);
    do_cap(0, 7, -7, 6, -1, 0, 0);
    do_cap(0, 7, -7, 6, -1, 0, 0);
    do_cap(0, 7, -7, 6, -1, 0, 0);
    check("post_rst_literal", 32'(ya), 32'(pack(7, 0, 7, 0)));
    drain(0, "post_rst");

    // Two tiles, no shift, signed output.
    do_cap(1, 1, 2, -3, 7, 0, 0);  check("t1_tc1", get_tc(1), 1);
    do_cap(1, 2, -1, -3, 7, 0, 0);
    check("t1_latency", 32'(vb), 1);
    check("t1_literal", 32'(yb), 32'(pack(3, 1, -6, 7)));
    drain(1, "t1");

    // Twenty tiles of +7: accumulator pins at 127 instead of wrapping.
    for (int i = 0; i < 19; i++) do_cap(2, 7, 7, 7, 7, 0, 0);
    check("sat_tc19", get_tc(2), 19);
    do_cap(2, 7, 7, 7, 7, 0, 0);
    check("sat_literal", 32'(yc), 32'(pack(3, 3, 3, 3)));
    check("sat_ovr", 32'(oc), 0);
    drain(2, "sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
